// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared encodings for the unified memory port arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic GRANT_CPU = 1'b0;
   localparam logic GRANT_DMA = 1'b1;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 15;
   localparam int CNT_W   = 4;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2  : two-input round-robin picker (req[0]=CPU, req[1]=DMA)
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       any
);

   always_comb begin
      any   = |req;
      grant = GRANT_CPU;
      // On a tie the side that was not served last goes next
      if (&req) begin
         grant = ~last_grant;
      end else if (req[1]) begin
         grant = GRANT_DMA;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : shares one multicycle memory port between core and DMA
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LAT = 2,
   parameter int AW  = 32,
   parameter int DW  = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_adr,
   input  logic [DW-1:0] cpu_wd,
   output logic [DW-1:0] cpu_rd,
   output logic          cpu_ready,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_adr,
   input  logic [DW-1:0] dma_wd,
   output logic [DW-1:0] dma_rd,
   output logic          dma_ready,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             grant_q, grant_d;
   logic             last_grant_q, last_grant_d;
   logic             we_q, we_d;
   logic [AW-1:0]    adr_q, adr_d;
   logic [DW-1:0]    wd_q, wd_d;
   logic [DW-1:0]    cpu_rd_q, cpu_rd_d;
   logic [DW-1:0]    dma_rd_q, dma_rd_d;

   logic             arb_grant;
   logic             arb_any;

   rr_arb2 u_rr_arb2 (
      .req        ({dma_req, cpu_req}),
      .last_grant (last_grant_q),
      .grant      (arb_grant),
      .any        (arb_any)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      adr_d        = adr_q;
      wd_d         = wd_q;
      cpu_rd_d     = cpu_rd_q;
      dma_rd_d     = dma_rd_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               grant_d = arb_grant;
               we_d    = (arb_grant == GRANT_DMA) ? dma_we  : cpu_we;
               adr_d   = (arb_grant == GRANT_DMA) ? dma_adr : cpu_adr;
               wd_d    = (arb_grant == GRANT_DMA) ? dma_wd  : cpu_wd;
               cnt_d   = CNT_W'(LAT - 1);
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) begin
               // Read data is only valid in the final access cycle
               if (!we_q) begin
                  if (grant_q == GRANT_DMA) dma_rd_d = mem_rd;
                  else                      cpu_rd_d = mem_rd;
               end
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         grant_q      <= GRANT_CPU;
         last_grant_q <= GRANT_DMA;
         we_q         <= 1'b0;
         adr_q        <= '0;
         wd_q         <= '0;
         cpu_rd_q     <= '0;
         dma_rd_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         adr_q        <= adr_d;
         wd_q         <= wd_d;
         cpu_rd_q     <= cpu_rd_d;
         dma_rd_q     <= dma_rd_d;
      end
   end

   assign mem_en    = (state_q == ST_BUSY);
   assign mem_we    = mem_en & we_q;
   assign mem_adr   = adr_q;
   assign mem_wd    = wd_q;
   assign cpu_ready = (state_q == ST_DONE) && (grant_q == GRANT_CPU);
   assign dma_ready = (state_q == ST_DONE) && (grant_q == GRANT_DMA);
   assign cpu_stall = cpu_req & ~cpu_ready;
   assign cpu_rd    = cpu_rd_q;
   assign dma_rd    = dma_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed table, corner sequences and random model check
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

   localparam int LAT = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, dma_req, dma_we;
   logic [AW-1:0] cpu_adr, dma_adr;
   logic [DW-1:0] cpu_wd, dma_wd;
   logic [DW-1:0] cpu_rd, dma_rd;
   logic          cpu_ready, cpu_stall, dma_ready;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   logic [31:0]   ecnt = '0;
   logic          use_hash = 1'b0;
   logic [DW-1:0] mem_rd_fix = '0;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [31:0] hash(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
   endfunction

   mem_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_adr   (cpu_adr),
      .cpu_wd    (cpu_wd),
      .cpu_rd    (cpu_rd),
      .cpu_ready (cpu_ready),
      .cpu_stall (cpu_stall),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_adr   (dma_adr),
      .dma_wd    (dma_wd),
      .dma_rd    (dma_rd),
      .dma_ready (dma_ready),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_adr   (mem_adr),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 32'd1;

   // Memory data changes every cycle so the capture cycle is observable
   assign mem_rd = use_hash ? (hash(mem_adr) ^ ecnt) : mem_rd_fix;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wd = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_adr = '0; dma_wd = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_mem_en",  32'(mem_en), 0);
      chk("rst_mem_we",  32'(mem_we), 0);
      chk("rst_mem_adr", mem_adr, 0);
      chk("rst_mem_wd",  mem_wd, 0);
      chk("rst_cpu_rdy", 32'(cpu_ready), 0);
      chk("rst_dma_rdy", 32'(dma_ready), 0);
      chk("rst_cpu_rd",  cpu_rd, 0);
      chk("rst_dma_rd",  dma_rd, 0);
   endtask

   typedef struct {
      logic        c_req;
      logic        c_we;
      logic [31:0] c_adr;
      logic [31:0] c_wd;
      logic [31:0] mrd;
      logic        e_en;
      logic        e_we;
      logic [31:0] e_adr;
      logic [31:0] e_wd;
      logic        e_rdy;
      logic        e_stall;
      logic [31:0] e_crd;
   } vec_t;

   vec_t tbl [9];

   // Random-phase model: one transaction in flight, timed from its grant edge
   bit          act, who, last, t_we, x_en, x_cr, x_dr, c_pend, d_pend;
   logic [31:0] t_adr, t_wd, e_crd, e_drd, e_drd_dir;
   int          e_g, n, slot, phase;

   initial begin
      reset = 1'b1;
      tbl[0] = '{1'b1, 1'b0, 32'h60, 32'h0, 32'h7,    1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b1, 32'h0};
      tbl[1] = '{1'b1, 1'b0, 32'h60, 32'h0, 32'h7,    1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b1, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 32'h60, 32'h0, 32'h7,    1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b1, 32'h0};
      tbl[3] = '{1'b0, 1'b0, 32'h60, 32'h0, 32'h7,    1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h7};
      tbl[4] = '{1'b1, 1'b1, 32'h64, 32'h7, 32'hDEAD, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b1, 32'h7};
      tbl[5] = '{1'b1, 1'b1, 32'h64, 32'h7, 32'hDEAD, 1'b1, 1'b1, 32'h64, 32'h7, 1'b0, 1'b1, 32'h7};
      tbl[6] = '{1'b1, 1'b1, 32'h64, 32'h7, 32'hDEAD, 1'b1, 1'b1, 32'h64, 32'h7, 1'b0, 1'b1, 32'h7};
      tbl[7] = '{1'b0, 1'b1, 32'h64, 32'h7, 32'hDEAD, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h7};
      tbl[8] = '{1'b0, 1'b0, 32'h64, 32'h7, 32'hDEAD, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h7};

      // CPU read then CPU write
      do_reset();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         cpu_req = tbl[i].c_req; cpu_we = tbl[i].c_we;
         cpu_adr = tbl[i].c_adr; cpu_wd = tbl[i].c_wd;
         mem_rd_fix = tbl[i].mrd;
         #1;
         chk($sformatf("tbl%0d_mem_en", i),  32'(mem_en),    32'(tbl[i].e_en));
         chk($sformatf("tbl%0d_mem_we", i),  32'(mem_we),    32'(tbl[i].e_we));
         chk($sformatf("tbl%0d_cpu_rdy", i), 32'(cpu_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_dma_rdy", i), 32'(dma_ready), 0);
         chk($sformatf("tbl%0d_stall", i),   32'(cpu_stall), 32'(tbl[i].e_stall));
         chk($sformatf("tbl%0d_cpu_rd", i),  cpu_rd,         tbl[i].e_crd);
         if (tbl[i].e_en) begin
            chk($sformatf("tbl%0d_mem_adr", i), mem_adr, tbl[i].e_adr);
            chk($sformatf("tbl%0d_mem_wd", i),  mem_wd,  tbl[i].e_wd);
         end
      end

      // Both requesters held high: strict alternation, 4-cycle spacing
      do_reset();
      cpu_req = 1'b1; cpu_adr = 32'h100;
      dma_req = 1'b1; dma_adr = 32'h200;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk); #1;
         slot  = (k - 1) / 4;
         phase = (k - 1) % 4;
         chk($sformatf("tie%0d_mem_en", k), 32'(mem_en), 32'(phase < 2));
         chk($sformatf("tie%0d_cpu_rdy", k), 32'(cpu_ready), 32'(phase == 2 && slot % 2 == 0));
         chk($sformatf("tie%0d_dma_rdy", k), 32'(dma_ready), 32'(phase == 2 && slot % 2 == 1));
         if (phase < 2) chk($sformatf("tie%0d_mem_adr", k), mem_adr, (slot % 2 == 0) ? 32'h100 : 32'h200);
      end

      // DMA-only burst of three reads
      do_reset();
      dma_req = 1'b1; dma_we = 1'b0; dma_adr = 32'h0; mem_rd_fix = 32'hA000_0000;
      e_drd_dir = '0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk); #1;
         slot  = (k - 1) / 4;
         phase = (k - 1) % 4;
         if (phase == 2) e_drd_dir = 32'hA000_0000 | 32'(slot * 4);
         chk($sformatf("dma%0d_rdy", k), 32'(dma_ready), 32'(phase == 2));
         chk($sformatf("dma%0d_rd", k), dma_rd, e_drd_dir);
         chk($sformatf("dma%0d_cpu_rd", k), cpu_rd, 0);
         if (phase < 2) chk($sformatf("dma%0d_mem_adr", k), mem_adr, 32'(slot * 4));
         if (phase == 2) begin
            dma_adr    = 32'((slot + 1) * 4);
            mem_rd_fix = 32'hA000_0000 | dma_adr;
            if (slot == 2) dma_req = 1'b0;
         end
      end

      // Reset in the second BUSY cycle of a CPU write
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h80; cpu_wd = 32'h55;
      @(negedge clk); #1;
      chk("rmid_en1", 32'(mem_en), 1);
      chk("rmid_we1", 32'(mem_we), 1);
      @(negedge clk); reset = 1'b1; #1;
      chk("rmid_en2", 32'(mem_en), 1);
      cpu_req = 1'b0;
      @(negedge clk); reset = 1'b0; #1;
      chk("rmid_en3",  32'(mem_en), 0);
      chk("rmid_we3",  32'(mem_we), 0);
      chk("rmid_adr3", mem_adr, 0);
      chk("rmid_rdy3", 32'(cpu_ready), 0);
      @(negedge clk); #1;
      chk("rmid_rdy4", 32'(cpu_ready), 0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h84; mem_rd_fix = 32'h33;
      @(negedge clk); #1;
      chk("rmid_en5",  32'(mem_en), 1);
      chk("rmid_adr5", mem_adr, 32'h84);
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("rmid_rdy7", 32'(cpu_ready), 1);
      chk("rmid_rd7",  cpu_rd, 32'h33);
      cpu_req = 1'b0;

      // Request dropped and address changed while BUSY
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h40; mem_rd_fix = 32'h99;
      @(negedge clk); #1;
      chk("drop_adr1", mem_adr, 32'h40);
      cpu_req = 1'b0; cpu_adr = 32'hFF;
      @(negedge clk); #1;
      chk("drop_adr2",   mem_adr, 32'h40);
      chk("drop_en2",    32'(mem_en), 1);
      chk("drop_stall2", 32'(cpu_stall), 0);
      @(negedge clk); #1;
      chk("drop_rdy3", 32'(cpu_ready), 1);
      chk("drop_rd3",  cpu_rd, 32'h99);
      for (int k = 4; k <= 6; k++) begin
         @(negedge clk); #1;
         chk($sformatf("drop_rdy%0d", k), 32'(cpu_ready), 0);
         chk($sformatf("drop_en%0d", k),  32'(mem_en), 0);
      end

      // Randomized traffic against the transaction-level model
      do_reset();
      use_hash = 1'b1;
      act = 1'b0; last = 1'b1; c_pend = 1'b0; d_pend = 1'b0;
      e_crd = '0; e_drd = '0; e_g = 0;
      for (int it = 0; it < 1500; it++) begin
         @(negedge clk);
         n = int'(ecnt);
         #1;
         if (act && n > e_g + LAT) act = 1'b0;
         x_en = act && n >= e_g && n < e_g + LAT;
         x_cr = act && n == e_g + LAT && !who;
         x_dr = act && n == e_g + LAT && who;
         if (act && n == e_g + LAT) begin
            last = who;
            if (!t_we) begin
               if (who) e_drd = hash(t_adr) ^ 32'(e_g + LAT - 1);
               else     e_crd = hash(t_adr) ^ 32'(e_g + LAT - 1);
            end
         end
         chk("rnd_mem_en",  32'(mem_en),    32'(x_en));
         chk("rnd_cpu_rdy", 32'(cpu_ready), 32'(x_cr));
         chk("rnd_dma_rdy", 32'(dma_ready), 32'(x_dr));
         chk("rnd_stall",   32'(cpu_stall), 32'(cpu_req & ~x_cr));
         chk("rnd_cpu_rd",  cpu_rd, e_crd);
         chk("rnd_dma_rd",  dma_rd, e_drd);
         if (x_en) begin
            chk("rnd_mem_we",  32'(mem_we), 32'(t_we));
            chk("rnd_mem_adr", mem_adr, t_adr);
            chk("rnd_mem_wd",  mem_wd, t_wd);
         end else begin
            chk("rnd_mem_we0", 32'(mem_we), 0);
         end
         if (x_cr) c_pend = 1'b0;
         if (x_dr) d_pend = 1'b0;
         if (!c_pend && $urandom_range(2) == 0) c_pend = 1'b1;
         if (!d_pend && $urandom_range(2) == 0) d_pend = 1'b1;
         cpu_req = c_pend;
         dma_req = d_pend;
         if (!c_pend || $urandom_range(3) == 0) begin
            cpu_we = 1'($urandom_range(1)); cpu_adr = $urandom & 32'hFFFF_FFFC; cpu_wd = $urandom;
         end
         if (!d_pend || $urandom_range(3) == 0) begin
            dma_we = 1'($urandom_range(1)); dma_adr = $urandom & 32'hFFFF_FFFC; dma_wd = $urandom;
         end
         if (!act && (cpu_req || dma_req)) begin
            who   = (cpu_req && dma_req) ? ~last : dma_req;
            act   = 1'b1;
            e_g   = n + 1;
            t_we  = who ? dma_we  : cpu_we;
            t_adr = who ? dma_adr : cpu_adr;
            t_wd  = who ? dma_wd  : cpu_wd;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single unified memory port of the multicycle ARM core. It shares the port between the core's fetch/load/store path and a DMA/boot-loader requester, and sequences each access over a fixed multi-cycle memory latency. It also raises a stall toward the controller FSM, so the FSM holds PCWrite/IRWrite/RegWrite until the core's access completes.

## Interface

Parameters:
- LAT, 2: memory access cycles per transfer; legal range 1..15
- AW, 32: address width
- DW, 32: data width

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  core access request; level, held until cpu_ready
- cpu_we  in  1  core write enable, qualified by cpu_req
- cpu_adr  in  AW  core byte address
- cpu_wd  in  DW  core write data
- cpu_rd  out  DW  core read data; valid while cpu_ready=1, held afterwards
- cpu_ready  out  1  one-cycle completion pulse for the core
- cpu_stall  out  1  combinational: cpu_req & ~cpu_ready
- dma_req, dma_we, dma_adr, dma_wd, dma_rd, dma_ready  same semantics as the cpu_* ports, for the DMA requester
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_adr  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  memory read data; valid in the last BUSY cycle

## Operation

- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - If any request is high, latch the winner's we/adr/wd into internal registers.
  - Record the winner as grant, load cnt = LAT-1, and go to BUSY.
  - With no request, stay in IDLE.
- Arbitration is 2-way round-robin on last_grant:
  - A sole requester always wins.
  - When both request, the requester that was not last granted wins.
  - last_grant resets to DMA, so the core wins the first tie.
- BUSY:
  - mem_en=1, and mem_we equals the latched we.
  - mem_adr and mem_wd are driven from the latched registers and are stable for all LAT cycles.
  - cnt decrements each cycle. When cnt==0, capture mem_rd into the granted requester's rd register (reads only) and go to DONE.
- DONE:
  - The granted requester's ready=1 for exactly one cycle. Update last_grant, then go to IDLE.
  - Requests are ignored in DONE. A req still high in the following IDLE cycle counts as a new request.
- The cpu_rd and dma_rd registers are independent. Each is updated only by its own completed reads and holds its value otherwise. Writes leave rd unchanged.
- A req dropped while in BUSY does not abort the access: the write is still committed and the ready pulse is still issued.
- Changes to the latched requester's adr/wd/we during BUSY have no effect.

## Timing

- Reset values: all ready=0, mem_en=0, mem_we=0, mem_adr=0, mem_wd=0, cpu_rd=0, dma_rd=0, cnt=0, grant=CPU, last_grant=DMA.
- Latency: with req sampled high in IDLE at edge 0, mem_en is high during cycles 1..LAT and ready is high in cycle LAT+1.
- Port occupancy is LAT+2 cycles per transfer, including the IDLE cycle.
- When both requesters stay continuously high, grants alternate strictly (CPU, DMA, CPU, ...).
- cpu_stall is combinational and has no registered delay. It is 1 from req assertion through the cycle before ready.
- Reset mid-access (reset high during BUSY or DONE):
  - Next state is IDLE and all outputs take their reset values.
  - No ready pulse is issued. A partially completed write may already be in memory; software must not rely on either outcome.
- LAT=1: BUSY lasts one cycle and cnt is loaded with 0.

## Structure

- Shared package mem_arb_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - the grant encoding (GRANT_CPU=1'b0, GRANT_DMA=1'b1)
  - the LAT range limits
- The controller includes this package so it can consume cpu_stall consistently.
- One sub-module: rr_arb2, a 2-input round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant, any.
  - It is purely combinational and instantiated once.
- Everything else (FSM, counter, latches, rd registers) lives in mem_arbiter.

## Test plan

- Reset, then a CPU read of 0x60 with mem_rd=0x7 (LAT=2): mem_en high for cycles 1–2 with mem_adr=0x60 and mem_we=0; cpu_ready is high in cycle 3 with cpu_rd=0x7; cpu_stall is high in cycles 0–2.
- CPU write adr=0x64, wd=0x7: mem_we=1 and mem_wd=0x7 for 2 cycles; cpu_ready pulses once; cpu_rd is unchanged.
- cpu_req and dma_req both high from reset release, held continuously: grant order is CPU, DMA, CPU, DMA, and each ready pulse comes 4 cycles apart.
- DMA-only burst of 3 reads (adr 0x0, 0x4, 0x8): dma_ready pulses 4 cycles apart, dma_rd follows mem_rd, and cpu_rd stays 0.
- Assert reset in the second BUSY cycle of a CPU write: no cpu_ready pulse; mem_en=0 on the next cycle; the FSM is in IDLE.
- Drop cpu_req and change cpu_adr to 0xFF during BUSY: mem_adr stays at the latched value and cpu_ready still pulses once.
